// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered MDU/load writebacks onto the register file write port.
// Optional pending-write query ports are built when WB_PENDING_QUERY_EN is defined.
module writeback_arbiter #(
  parameter int unsigned COUNT        = 32,
  parameter int unsigned BUS_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned AddrWidth   = $clog2(COUNT),
  localparam int unsigned PtrWidth    = $clog2(FIFO_DEPTH),
  localparam int unsigned CntWidth    = PtrWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [AddrWidth-1:0] alu_addr_i,
  input  logic [BUS_WIDTH-1:0] alu_data_i,
  input  logic                 mdu_valid_i,
  output logic                 mdu_ready_o,
  input  logic [AddrWidth-1:0] mdu_addr_i,
  input  logic [BUS_WIDTH-1:0] mdu_data_i,
  output logic                 wr_en_o,
  output logic [AddrWidth-1:0] write_addr_o,
  output logic [BUS_WIDTH-1:0] data_in_o,
`ifdef WB_PENDING_QUERY_EN
  input  logic [AddrWidth-1:0] query_addr_i,
  output logic                 query_pending_o,
`endif
  output logic [CntWidth-1:0]  fifo_count_o
);

  localparam int unsigned StarveWidth = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {StNormal, StForce} state_e;

  state_e                 state_q, state_d;
  logic [StarveWidth-1:0] starve_q, starve_d;
  logic [PtrWidth-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]    count_q, count_d;
  logic                   wr_en_q;
  logic [AddrWidth-1:0]   write_addr_q;
  logic [BUS_WIDTH-1:0]   data_in_q;

  logic [AddrWidth-1:0]   addr_mem_q [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0]   data_mem_q [FIFO_DEPTH];

  logic                   fifo_empty, fifo_full, push, pop, alu_fire, win;
  logic [AddrWidth-1:0]   win_addr;
  logic [BUS_WIDTH-1:0]   win_data;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CntWidth'(FIFO_DEPTH));
    mdu_ready_o = !fifo_full;
    push        = mdu_valid_i && !fifo_full;
    alu_ready_o = (state_q == StNormal);
    alu_fire    = alu_valid_i && alu_ready_o;
    pop         = !fifo_empty && ((state_q == StForce) || !alu_fire);
    count_d     = count_q + CntWidth'(push) - CntWidth'(pop);

    unique case (state_q)
      StNormal: begin
        if (pop || fifo_empty) begin
          starve_d = '0;
        end else if (alu_valid_i) begin
          if (starve_q == StarveWidth'(STARVE_LIMIT - 1)) begin
            state_d  = StForce;
            starve_d = '0;
          end else begin
            starve_d = starve_q + StarveWidth'(1);
          end
        end
      end
      StForce: begin
        state_d  = StNormal;
        starve_d = '0;
      end
      default: state_d = StNormal;
    endcase

    win      = alu_fire || pop;
    win_addr = alu_fire ? alu_addr_i : addr_mem_q[rd_ptr_q];
    win_data = alu_fire ? alu_data_i : data_mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StNormal;
      starve_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      write_addr_q <= '0;
      data_in_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      // Writes to $zero still consume their slot but never reach the register file.
      wr_en_q <= win && (win_addr != '0);
      if (win) begin
        write_addr_q <= win_addr;
        data_in_q    <= win_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= mdu_addr_i;
      data_mem_q[wr_ptr_q] <= mdu_data_i;
    end
  end

`ifdef WB_PENDING_QUERY_EN
  always_comb begin
    query_pending_o = 1'b0;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      if ((CntWidth'(k) < count_q) && (query_addr_i != '0) &&
          (addr_mem_q[rd_ptr_q + PtrWidth'(k)] == query_addr_i)) begin
        query_pending_o = 1'b1;
      end
    end
  end
`endif

  assign wr_en_o      = wr_en_q;
  assign write_addr_o = write_addr_q;
  assign data_in_o    = data_in_q;
  assign fifo_count_o = count_q;

endmodule
